// File: rtl/cart_bus_master_if.sv
// CPU request/response channel plus Game Boy cartridge pins, grouped for cart_bus_master.
// The master modport is the bus cycle generator; slave is the CPU + cartridge side.
interface cart_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] cart_a;
  logic [7:0]  cart_d_out;
  logic        cart_d_oe;
  logic [7:0]  cart_d_in;
  logic        cart_n_rd;
  logic        cart_n_wr;
  logic        cart_n_cs;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, cart_d_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output cart_a, cart_d_out, cart_d_oe, cart_n_rd, cart_n_wr, cart_n_cs
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, cart_d_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  cart_a, cart_d_out, cart_d_oe, cart_n_rd, cart_n_wr, cart_n_cs
  );
endinterface

// File: rtl/cart_bus_master.sv
// Cartridge bus cycle generator: one CPU request becomes a SETUP/STROBE/HOLD pin sequence.
// Every pin and response output comes straight from a flop.
module cart_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic               clk,
  input  logic               n_rst,
  cart_bus_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0]  SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0]  STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0]  HOLD_LOAD   = 4'(HOLD_CYC - 1);
  localparam logic [15:0] CART_TOP    = 16'hBFFF;
  localparam logic [15:0] SRAM_BASE   = 16'hA000;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        write_reg, write_next;
  logic        req_ready_reg, req_ready_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_err_reg, rsp_err_next;
  logic [7:0]  rsp_rdata_reg, rsp_rdata_next;
  logic [15:0] cart_a_reg, cart_a_next;
  logic [7:0]  cart_d_out_reg, cart_d_out_next;
  logic        cart_d_oe_reg, cart_d_oe_next;
  logic        cart_n_rd_reg, cart_n_rd_next;
  logic        cart_n_wr_reg, cart_n_wr_next;
  logic        cart_n_cs_reg, cart_n_cs_next;
  logic        accept;

  assign accept = bus.req_valid && req_ready_reg;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      write_reg      <= 1'b0;
      req_ready_reg  <= 1'b1;
      rsp_valid_reg  <= 1'b0;
      rsp_err_reg    <= 1'b0;
      rsp_rdata_reg  <= 8'hFF;
      cart_a_reg     <= 16'h0000;
      cart_d_out_reg <= 8'h00;
      cart_d_oe_reg  <= 1'b0;
      cart_n_rd_reg  <= 1'b1;
      cart_n_wr_reg  <= 1'b1;
      cart_n_cs_reg  <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      write_reg      <= write_next;
      req_ready_reg  <= req_ready_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_err_reg    <= rsp_err_next;
      rsp_rdata_reg  <= rsp_rdata_next;
      cart_a_reg     <= cart_a_next;
      cart_d_out_reg <= cart_d_out_next;
      cart_d_oe_reg  <= cart_d_oe_next;
      cart_n_rd_reg  <= cart_n_rd_next;
      cart_n_wr_reg  <= cart_n_wr_next;
      cart_n_cs_reg  <= cart_n_cs_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    write_next      = write_reg;
    rsp_valid_next  = 1'b0;
    rsp_err_next    = 1'b0;
    rsp_rdata_next  = rsp_rdata_reg;
    cart_a_next     = cart_a_reg;
    cart_d_out_next = cart_d_out_reg;
    cart_d_oe_next  = cart_d_oe_reg;
    cart_n_rd_next  = cart_n_rd_reg;
    cart_n_wr_next  = cart_n_wr_reg;
    cart_n_cs_next  = cart_n_cs_reg;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bus.req_addr <= CART_TOP) begin
            state_next     = SETUP;
            cnt_next       = SETUP_LOAD;
            write_next     = bus.req_write;
            cart_a_next    = bus.req_addr;
            cart_n_cs_next = !(bus.req_addr >= SRAM_BASE);
            if (bus.req_write) begin
              cart_d_out_next = bus.req_wdata;
              cart_d_oe_next  = 1'b1;
            end
          end else begin
            // Outside the cartridge window: answer immediately, pins untouched.
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = 8'hFF;
          end
        end
      end
      SETUP: begin
        if (cnt_reg == 4'd0) begin
          state_next     = STROBE;
          cnt_next       = STROBE_LOAD;
          cart_n_rd_next = write_reg;
          cart_n_wr_next = !write_reg;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_reg == 4'd0) begin
          state_next     = HOLD;
          cnt_next       = HOLD_LOAD;
          cart_n_rd_next = 1'b1;
          cart_n_wr_next = 1'b1;
          // Data is captured at the edge that closes the last strobe cycle.
          if (!write_reg) begin
            rsp_rdata_next = bus.cart_d_in;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_reg == 4'd0) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b1;
          cart_n_cs_next = 1'b1;
          cart_d_oe_next = 1'b0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered ready, so the CPU side sees no decode of the state vector.
  assign req_ready_next = (state_next == IDLE);

  assign bus.req_ready  = req_ready_reg;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_err    = rsp_err_reg;
  assign bus.rsp_rdata  = rsp_rdata_reg;
  assign bus.cart_a     = cart_a_reg;
  assign bus.cart_d_out = cart_d_out_reg;
  assign bus.cart_d_oe  = cart_d_oe_reg;
  assign bus.cart_n_rd  = cart_n_rd_reg;
  assign bus.cart_n_wr  = cart_n_wr_reg;
  assign bus.cart_n_cs  = cart_n_cs_reg;

endmodule

// File: tb/tb_cart_bus_master.sv
// Directed bench for cart_bus_master with default timing (1/4/1): vector table plus
// hand-written back-to-back and reset-mid-strobe sequences.
module tb_cart_bus_master;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  cart_bus_master_if bus();

  cart_bus_master dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.master)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic        exp_cs_n;
    logic        exp_err;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[10];
  int tests  = 0;
  int failed = 0;
  logic [15:0] prev_a;
  logic [7:0]  prev_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; starts by presenting the request (cycle 0).
  task automatic do_txn(input int idx, input vec_t v);
    bit strobe, active;
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    chk($sformatf("v%0d ready_c0", idx), 32'(bus.req_ready), 32'd1);
    if (v.exp_err) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk($sformatf("v%0d oor_valid", idx), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("v%0d oor_err", idx), 32'(bus.rsp_err), 32'd1);
      chk($sformatf("v%0d oor_rdata", idx), 32'(bus.rsp_rdata), 32'hFF);
      chk($sformatf("v%0d oor_ready", idx), 32'(bus.req_ready), 32'd1);
      chk($sformatf("v%0d oor_a", idx), 32'(bus.cart_a), 32'(prev_a));
      chk($sformatf("v%0d oor_dout", idx), 32'(bus.cart_d_out), 32'(prev_d));
      chk($sformatf("v%0d oor_pins", idx),
          {28'd0, bus.cart_n_cs, bus.cart_d_oe, bus.cart_n_rd, bus.cart_n_wr}, 32'b1011);
    end else begin
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        if (c == 1) bus.req_valid = 1'b0;
        strobe = (c >= 2 && c <= 5);
        active = (c >= 1 && c <= 6);
        bus.cart_d_in = (c >= 2 && c <= 5) ? v.din : ~v.din;
        chk($sformatf("v%0d c%0d n_rd", idx, c), 32'(bus.cart_n_rd), 32'(!(strobe && !v.wr)));
        chk($sformatf("v%0d c%0d n_wr", idx, c), 32'(bus.cart_n_wr), 32'(!(strobe && v.wr)));
        chk($sformatf("v%0d c%0d n_cs", idx, c), 32'(bus.cart_n_cs), 32'(active ? v.exp_cs_n : 1'b1));
        chk($sformatf("v%0d c%0d d_oe", idx, c), 32'(bus.cart_d_oe), 32'(active && v.wr));
        chk($sformatf("v%0d c%0d a", idx, c), 32'(bus.cart_a), 32'(v.addr));
        if (v.wr) chk($sformatf("v%0d c%0d dout", idx, c), 32'(bus.cart_d_out), 32'(v.wdata));
        chk($sformatf("v%0d c%0d rsp_valid", idx, c), 32'(bus.rsp_valid), 32'(c == 7));
        chk($sformatf("v%0d c%0d ready", idx, c), 32'(bus.req_ready), 32'(c == 7));
      end
      chk($sformatf("v%0d rdata", idx), 32'(bus.rsp_rdata), 32'(v.exp_rdata));
      chk($sformatf("v%0d err", idx), 32'(bus.rsp_err), 32'd0);
      prev_a = v.addr;
      if (v.wr) prev_d = v.wdata;
    end
  endtask

  initial begin
    //        wr    addr      wdata  din    cs_n  err   rdata
    vecs[0] = '{1'b0, 16'h0150, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h3C};
    vecs[1] = '{1'b1, 16'hA010, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h3C};
    vecs[2] = '{1'b0, 16'hBFFF, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h5A};
    vecs[3] = '{1'b0, 16'hA000, 8'h00, 8'h81, 1'b0, 1'b0, 8'h81};
    vecs[4] = '{1'b0, 16'h9FFF, 8'h00, 8'h7E, 1'b1, 1'b0, 8'h7E};
    vecs[5] = '{1'b0, 16'hC000, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF};
    vecs[6] = '{1'b1, 16'hC123, 8'h99, 8'h00, 1'b1, 1'b1, 8'hFF};
    vecs[7] = '{1'b0, 16'h4000, 8'h00, 8'h11, 1'b1, 1'b0, 8'h11};
    vecs[8] = '{1'b1, 16'h2000, 8'h01, 8'h00, 1'b1, 1'b0, 8'h11};
    vecs[9] = '{1'b0, 16'hC123, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF};

    n_rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 8'h00;
    bus.cart_d_in = 8'h00;
    prev_a = 16'h0000;
    prev_d = 8'h00;

    // Reset held for two edges
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(bus.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst rdata", 32'(bus.rsp_rdata), 32'hFF);
    chk("rst a", 32'(bus.cart_a), 32'h0000);
    chk("rst dout", 32'(bus.cart_d_out), 32'h00);
    chk("rst pins", {28'd0, bus.cart_n_cs, bus.cart_d_oe, bus.cart_n_rd, bus.cart_n_wr}, 32'b1011);
    n_rst = 1'b1;
    @(negedge clk);
    chk("post-rst ready", 32'(bus.req_ready), 32'd1);
    chk("post-rst rsp_valid", 32'(bus.rsp_valid), 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_txn(i, vecs[i]);
      $display("[TB] vector %0d wr=%0b addr=0x%04h done (tests=%0d failed=%0d)",
               i, vecs[i].wr, vecs[i].addr, tests, failed);
    end

    // Back-to-back: write 0x2000, read 0x4000 held while busy, accepted in rsp cycle
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h2000;
    bus.req_wdata = 8'h03;
    chk("b2b ready_c0", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h4000;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("b2b c%0d a", c), 32'(bus.cart_a), 32'h2000);
      chk($sformatf("b2b c%0d dout", c), 32'(bus.cart_d_out), 32'h03);
      chk($sformatf("b2b c%0d ready", c), 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    chk("b2b c7 rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("b2b c7 ready", 32'(bus.req_ready), 32'd1);
    chk("b2b c7 cs/oe", {30'd0, bus.cart_n_cs, bus.cart_d_oe}, 32'b10);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b c8 a", 32'(bus.cart_a), 32'h4000);
    chk("b2b c8 pins", {28'd0, bus.cart_n_cs, bus.cart_d_oe, bus.cart_n_rd, bus.cart_n_wr}, 32'b1011);
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      bus.cart_d_in = (c <= 5) ? 8'h77 : 8'h88;
      chk($sformatf("b2b r%0d n_rd", c), 32'(bus.cart_n_rd), 32'(!(c <= 5)));
      chk($sformatf("b2b r%0d n_wr", c), 32'(bus.cart_n_wr), 32'd1);
      chk($sformatf("b2b r%0d rsp_valid", c), 32'(bus.rsp_valid), 32'(c == 7));
    end
    chk("b2b rdata", 32'(bus.rsp_rdata), 32'h77);
    $display("[TB] back-to-back done (tests=%0d failed=%0d)", tests, failed);

    // Reset during the strobe of an SRAM write
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'hA020;
    bus.req_wdata = 8'h5A;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rms c2 n_wr", 32'(bus.cart_n_wr), 32'd0);
    @(negedge clk);
    chk("rms c3 n_wr", 32'(bus.cart_n_wr), 32'd0);
    chk("rms c3 n_cs", 32'(bus.cart_n_cs), 32'd0);
    n_rst = 1'b0;
    @(negedge clk);
    chk("rms pins", {28'd0, bus.cart_n_cs, bus.cart_d_oe, bus.cart_n_rd, bus.cart_n_wr}, 32'b1011);
    chk("rms a", 32'(bus.cart_a), 32'h0000);
    chk("rms dout", 32'(bus.cart_d_out), 32'h00);
    chk("rms ready", 32'(bus.req_ready), 32'd1);
    chk("rms rdata", 32'(bus.rsp_rdata), 32'hFF);
    n_rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("rms after%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd0);
    end
    $display("[TB] reset mid-strobe done (tests=%0d failed=%0d)", tests, failed);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cart_bus_master.md
# cart_bus_master

Cartridge bus cycle generator. Turns single-beat CPU memory requests (valid/ready) into correctly sequenced Game Boy cartridge pin activity (A[15:0], D[7:0], n_RD, n_WR, n_CS), and returns read data. It sits directly upstream of `cartridge_interface` and drives the `pinout` fields that block consumes.

## Interface
- `SETUP_CYC`, default 1: cycles the address and n_CS are stable before the strobe; legal range 1..15.
- `STROBE_CYC`, default 4: cycles n_RD or n_WR is held low; legal range 1..15.
- `HOLD_CYC`, default 1: cycles the address, n_CS and write data are held after the strobe; legal range 1..15.

Ports:
- `clk` in 1: system clock.
- `n_rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when both `req_valid` and `req_ready` are high.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 16: byte address.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 8: read data, valid with `rsp_valid`.
- `rsp_err` out 1: address outside the cartridge range, valid with `rsp_valid`.
- `cart_a` out 16: to A15..A0.
- `cart_d_out` out 8: write data to D7..D0.
- `cart_d_oe` out 1: D-bus drive enable.
- `cart_d_in` in 8: D7..D0 as seen from the cartridge.
- `cart_n_rd` out 1: read strobe, active low.
- `cart_n_wr` out 1: write strobe, active low.
- `cart_n_cs` out 1: SRAM select, active low.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, plus an internal down-counter (4 bits) that is loaded on each state entry.
- IDLE:
  - `req_ready`=1.
  - On accept with `req_addr` ≤ 0xBFFF: latch the address, data and write flag into registers; drive `cart_a`; drive `cart_n_cs`=0 when 0xA000 ≤ addr ≤ 0xBFFF, else 1.
  - For a write, `cart_d_out`=wdata and `cart_d_oe`=1.
  - Then go to SETUP.
- Accept with `req_addr` ≥ 0xC000:
  - No pin change, stay in IDLE.
  - Next cycle: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0xFF.
  - Writes to this range are dropped.
- SETUP, for SETUP_CYC cycles, then STROBE.
- STROBE, for STROBE_CYC cycles: `cart_n_rd`=0 for a read or `cart_n_wr`=0 for a write.
  - For a read, `cart_d_in` is registered into `rsp_rdata` at the clock edge that ends the last STROBE cycle.
- HOLD, for HOLD_CYC cycles: both strobes high; `cart_a`, `cart_n_cs`, `cart_d_out` and `cart_d_oe` stay held. Then go to IDLE with `rsp_valid`=1 and `rsp_err`=0 for one cycle.
- On entry to IDLE:
  - `cart_n_cs`=1 and `cart_d_oe`=0.
  - `cart_a` and `cart_d_out` keep their last values; no glitch to 0.
- `cart_n_rd` and `cart_n_wr` are never low at the same time. `cart_d_oe`=1 only during write transactions.
- `rsp_rdata` holds its value until the next read completes. Write completions leave it unchanged.
- All outputs are registered; no combinational path from `cart_d_in` or `req_*` to any pin.

## Timing
- Reset values, applied at the first rising edge with `n_rst`=0:
  - IDLE, `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0xFF.
  - `cart_a`=0x0000, `cart_d_out`=0x00, `cart_d_oe`=0.
  - `cart_n_rd`=1, `cart_n_wr`=1, `cart_n_cs`=1.
- Reset mid-transaction: the pins return to their reset values at that edge. No `rsp_valid` is produced for the aborted request.
- Latency, counting the accept cycle as cycle 0:
  - Pins change in cycle 1.
  - The strobe is low in cycles SETUP_CYC+1 .. SETUP_CYC+STROBE_CYC.
  - `rsp_valid` is high in cycle SETUP_CYC+STROBE_CYC+HOLD_CYC+1, which is cycle 7 with the defaults.
- `req_ready`=0 in SETUP, STROBE and HOLD. `req_ready`=1 in the same cycle `rsp_valid`=1, so a back-to-back accept is legal there.
  - A back-to-back request re-drives the pins in the following cycle.
  - Sustained throughput is one transaction per SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles.
- Out-of-range requests: 1-cycle latency, and `req_ready` stays 1.
- `req_*` inputs are ignored whenever `req_ready`=0.

## Test plan
- **Reset:** drive `n_rst`=0 for 2 cycles. All outputs must be at their reset values; `req_ready`=1 in the first cycle after `n_rst` goes high.
- **ROM read, defaults:** read 0x0150 with `cart_d_in`=0x3C during the strobe.
  - `cart_a`=0x0150 and `cart_n_cs`=1.
  - `cart_n_rd` low in cycles 2–5.
  - `rsp_valid` in cycle 7 with `rsp_rdata`=0x3C and `rsp_err`=0.
- **SRAM write:** write 0xA5 to 0xA010.
  - `cart_n_cs`=0 and `cart_d_oe`=1 in cycles 1–6.
  - `cart_n_wr` low in cycles 2–5, `cart_n_rd` stays 1.
  - `cart_d_out`=0xA5.
  - `rsp_valid` in cycle 7; in cycle 7 itself, `cart_d_oe`=0 and `cart_n_cs`=1.
- **Back-to-back:** a write to 0x2000 (MBC bank register) followed by a held read of 0x4000. The second accept happens in the `rsp_valid` cycle of the first, and `cart_a`=0x4000 in the next cycle.
- **Out of range:** read 0xC123. `rsp_valid`=1, `rsp_err`=1 and `rsp_rdata`=0xFF one cycle later; every `cart_*` output is unchanged.
- **Reset mid-strobe:** assert `n_rst`=0 in cycle 3 of an SRAM write. Strobes, `cart_n_cs` and `cart_d_oe` are inactive at the next edge, and no `rsp_valid` appears afterwards.
